// File: rtl/bbox_pixel_scanner_if.sv
// Pixel coordinate stream from the bbox scanner to the edge-test/shading stage.
// Coordinates are signed 24.8 with a zero fraction.
interface bbox_pixel_scanner_if;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] out_x;
   logic signed [31:0] out_y;
   logic               out_last;

   modport master (output out_valid, output out_x, output out_y, output out_last,
                   input  out_ready);
   modport slave  (input  out_valid, input  out_x, input  out_y, input  out_last,
                   output out_ready);
endinterface

// File: rtl/bbox_pixel_scanner.sv
// Clips a ceiled 24.8 triangle bounding box to the screen and streams every
// covered pixel coordinate in row-major order, one per accepted transfer.
module bbox_pixel_scanner #(
   parameter int FRAC_BITS = 8,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int CNT_W     = 20
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     start,
   input  logic signed [31:0]       xmin,
   input  logic signed [31:0]       xmax,
   input  logic signed [31:0]       ymin,
   input  logic signed [31:0]       ymax,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         pix_count,
   bbox_pixel_scanner_if.master     pix
);
   localparam logic signed [31:0] STEP  = 32'sd1 <<< FRAC_BITS;
   localparam logic signed [31:0] X_LIM = SCREEN_W <<< FRAC_BITS;
   localparam logic signed [31:0] Y_LIM = SCREEN_H <<< FRAC_BITS;

   typedef enum logic [1:0] {S_IDLE, S_CLIP, S_SCAN, S_DONE} state_t;

   function automatic logic signed [31:0] fx_floor(input logic signed [31:0] v);
      return v & ~(STEP - 32'sd1);
   endfunction

   function automatic logic signed [31:0] clamp_lo0(input logic signed [31:0] v);
      return (v < 32'sd0) ? 32'sd0 : v;
   endfunction

   function automatic logic signed [31:0] clamp_hi(input logic signed [31:0] v,
                                                   input logic signed [31:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   state_t             state_q, state_d;
   logic signed [31:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic signed [31:0] ymin_q, ymin_d, ymax_q, ymax_d;
   logic signed [31:0] x_q, x_d, y_q, y_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // The bound registers hold raw bounds in CLIP and clipped bounds during SCAN.
   logic signed [31:0] cx0, cx1, cy0, cy1;
   logic signed [31:0] x_step, y_step;
   logic               x_fits, y_fits;

   assign cx0    = clamp_lo0(fx_floor(xmin_q));
   assign cx1    = clamp_hi(fx_floor(xmax_q), X_LIM);
   assign cy0    = clamp_lo0(fx_floor(ymin_q));
   assign cy1    = clamp_hi(fx_floor(ymax_q), Y_LIM);
   assign x_step = x_q + STEP;
   assign y_step = y_q + STEP;
   assign x_fits = x_step < xmax_q;
   assign y_fits = y_step < ymax_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymin_q  <= '0;
         ymax_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymin_d  = ymin_q;
      ymax_d  = ymax_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               xmin_d  = xmin;
               xmax_d  = xmax;
               ymin_d  = ymin;
               ymax_d  = ymax;
               cnt_d   = '0;
               state_d = S_CLIP;
            end
         end
         S_CLIP: begin
            xmin_d = cx0;
            xmax_d = cx1;
            ymin_d = cy0;
            ymax_d = cy1;
            if (cx0 >= cx1 || cy0 >= cy1) begin
               state_d = S_DONE;
            end else begin
               x_d     = cx0;
               y_d     = cy0;
               cnt_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (pix.out_ready) begin
               cnt_d = sat_inc(cnt_q);
               if (x_fits) begin
                  x_d = x_step;
               end else if (y_fits) begin
                  x_d = xmin_q;
                  y_d = y_step;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q != S_IDLE);
      done          = (state_q == S_DONE);
      pix.out_valid = (state_q == S_SCAN);
      pix.out_last  = (state_q == S_SCAN) && !x_fits && !y_fits;
      pix.out_x     = x_q;
      pix.out_y     = y_q;
      pix_count     = cnt_q;
   end
endmodule

// File: doc/bbox_pixel_scanner.md
Name: bbox_pixel_scanner

Overview:
Consumes a triangle bounding box whose bounds are already ceiled, in 24.8 fixed point, and emits each covered pixel coordinate in row-major order. Output uses a valid/ready stream to the per-pixel edge-test/shading stage. The box is clipped to the screen before scanning. One pixel per cycle when downstream is always ready.

Parameters:
FRAC_BITS, 8, fractional bits of the fixed-point format (24.8)
SCREEN_W, 640, screen width in pixels; x clip bound
SCREEN_H, 480, screen height in pixels; y clip bound
CNT_W, 20, width of the pixel counter

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
xmin  in  32  signed 24.8, inclusive left bound
xmax  in  32  signed 24.8, exclusive right bound
ymin  in  32  signed 24.8, inclusive top bound
ymax  in  32  signed 24.8, exclusive bottom bound
busy  out  1  high in every state except IDLE
out_valid  out  1  pixel coordinate available
out_ready  in  1  downstream accepts
out_x  out  32  pixel x, 24.8, fraction always 0
out_y  out  32  pixel y, 24.8, fraction always 0
out_last  out  1  qualifies the final pixel of the box
done  out  1  one-cycle pulse when the box is finished
pix_count  out  CNT_W  pixels transferred for the current or last box

Behaviour:
- Interface: reset RESET, synchronous, active-high; clock CLK.
- Reset: state=IDLE; busy, out_valid, out_last and done = 0; out_x, out_y and pix_count = 0.
- RESET has priority in every state. If asserted mid-scan: the scan is abandoned, outputs return to reset values on the next edge, and no done pulse is produced.
- States:
  - IDLE: on start=1, latch all four bounds, go to CLIP.
  - CLIP: one cycle.
    - Clear bits [7:0] of each latched bound (floor).
    - Clamp xmin and ymin to at least 0.
    - Clamp xmax to at most SCREEN_W<<8; clamp ymax to at most SCREEN_H<<8.
    - Comparisons are signed.
    - If clipped xmin >= xmax or ymin >= ymax, go to DONE.
    - Otherwise load x=xmin, y=ymin, clear pix_count, go to SCAN.
  - SCAN:
    - out_valid=1, out_x=x, out_y=y.
    - out_last=1 iff x+256 >= xmax and y+256 >= ymax.
    - On out_valid and out_ready, pix_count increments, then:
      - if the x step stays in the box, x += 256;
      - else if the y step stays in the box, x = xmin and y += 256;
      - else go to DONE.
    - With no transfer, out_x, out_y and out_last hold stable.
  - DONE: done=1 for exactly one cycle, out_valid=0, next state IDLE.
- Latency: start sampled at edge N. out_valid rises after edge N+1, so the first pixel is presentable in cycle N+2.
  - Empty box: done is high in cycle N+2.
  - Non-empty box: done is high the cycle after the out_last transfer.
- start while busy is ignored; the new bounds are not latched.
- start may be reasserted in the cycle after done is seen; there is no back-to-back overlap.
- Arithmetic: all coordinate arithmetic is 32-bit signed. The step is 1<<FRAC_BITS.
- pix_count saturates at all-ones and holds its value after DONE until the next accepted start.

Test Plan:
1. Basic 2x2, ready=1:
   - xmin=0x0A00, xmax=0x0C00, ymin=0x0500, ymax=0x0700; start at cycle 0.
   - Required: valid in cycles 2-5 with (0x0A00,0x0500), (0x0B00,0x0500), (0x0A00,0x0600), (0x0B00,0x0600).
   - out_last only in cycle 5, done in cycle 6, pix_count=4.
2. Backpressure on the same box:
   - out_ready pattern 0,1,0,0,1,1,0,1.
   - Required: the coordinate sequence is identical and each value holds while ready=0; done follows the 4th transfer; out_last is never asserted early.
3. Empty box:
   - xmin=xmax=0x1000.
   - Required: out_valid never rises, done in cycle 2, pix_count=0.
4. Clipping:
   - xmin=-0x0300, xmax=0x0200, ymin=0x01DF00, ymax=0x01E500 with SCREEN_H=480.
   - Required: x ∈ {0x0000,0x0100} and y=0x01DF00 only; 2 pixels.
   - Variant: a fully offscreen box gives done at cycle 2 with no pixels.
5. Fractional bounds and ignored start:
   - xmin=0x0A80, xmax=0x0BFF, y one row; start pulsed again during SCAN.
   - Required: a single pixel x=0x0A00 and no second scan.
6. Reset mid-scan:
   - RESET asserted after the 2nd transfer of scenario 1.
   - Required: out_valid=0 and busy=0 next cycle, no done pulse; a new start then scans correctly from the first pixel.
